// File: rtl/dg0045_pkg.sv
// rtl/dg0045_pkg.sv - shared phase constants, sizes and FSM state type for the ROM server
package dg0045_pkg;

  localparam int         ROM_AW   = 10;
  localparam logic [2:0] P_HI     = 3'd2;
  localparam logic [2:0] P_FETCH  = 3'd3;
  localparam logic [2:0] P_HOLD   = 3'd4;
  localparam logic [7:0] NOP_BYTE = 8'h00;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LD_IDLE = 2'd1,
    LD_WR   = 2'd2
  } state_t;

endpackage

// File: rtl/dg0045_rom_server_if.sv
// rtl/dg0045_rom_server_if.sv - load-port handshake bundle between a loader and the ROM server
interface dg0045_rom_server_if;
  import dg0045_pkg::*;

  logic              ld_en;
  logic [ROM_AW-1:0] ld_base;
  logic              ld_valid;
  logic [7:0]        ld_data;
  logic              ld_ready;

  modport master (
    output ld_en, ld_base, ld_valid, ld_data,
    input  ld_ready
  );

  modport slave (
    input  ld_en, ld_base, ld_valid, ld_data,
    output ld_ready
  );

endinterface

// File: rtl/dg0045_rom_1kx8.sv
// rtl/dg0045_rom_1kx8.sv - 1Kx8 program store, synchronous write, combinational read
module dg0045_rom_1kx8
  import dg0045_pkg::*;
(
  input  logic              clk_in,
  input  logic              we,
  input  logic [ROM_AW-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ROM_AW-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [0:(1<<ROM_AW)-1];

  // contents survive reset; only the load port changes them
  always_ff @(posedge clk_in) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dg0045_rom_server.sv
// rtl/dg0045_rom_server.sv - serves instruction bytes to the DG0045 core over its multiplexed PC pins
module dg0045_rom_server
  import dg0045_pkg::*;
(
  input  logic              clk_in,
  input  logic              RESET,
  input  logic [4:0]        PC_HL,
  output logic              PC_MUX,
  output logic [7:0]        rom_data,
  input  logic              ld_en,
  input  logic [ROM_AW-1:0] ld_base,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic [ROM_AW-1:0] fetch_addr,
  output logic              fetch_stb
);

  state_t            state, state_nxt;
  logic [2:0]        p;
  logic [4:0]        hi_lat;
  logic [7:0]        hold_q;
  logic [ROM_AW-1:0] ptr;
  logic [ROM_AW-1:0] raddr;
  logic [7:0]        rdata;
  logic              we;
  logic              fetch_now;
  logic              fetch_q;
  // set while loading; keeps the stale hold byte off the bus until the next real fetch
  logic              stale;

  assign raddr     = {hi_lat, PC_HL};
  assign fetch_now = (state == RUN) && (p == P_FETCH);
  assign we        = ld_valid && ld_ready;
  assign PC_MUX    = (p == P_HI);
  assign fetch_stb = fetch_q && (p == P_HOLD);

  dg0045_rom_1kx8 u_rom (
    .clk_in (clk_in),
    .we     (we),
    .waddr  (ptr),
    .wdata  (ld_data),
    .raddr  (raddr),
    .rdata  (rdata)
  );

  // free-running phase counter mirroring the core's clock divider
  always_ff @(posedge clk_in or negedge RESET) begin
    if (!RESET) p <= '0;
    else        p <= p + 3'd1;
  end

  // FSM state register and load write pointer
  always_ff @(posedge clk_in or negedge RESET) begin
    if (!RESET) begin
      state <= RUN;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == RUN && ld_en) ptr <= ld_base;
      else if (we)               ptr <= ptr + ROM_AW'(1);
    end
  end

  // next-state and load handshake
  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    case (state)
      RUN: begin
        if (ld_en) state_nxt = LD_IDLE;
      end
      LD_IDLE: begin
        ld_ready = ld_en;
        if (ld_valid && ld_en)        state_nxt = LD_WR;
        else if (!ld_en && !ld_valid) state_nxt = RUN;
      end
      LD_WR: begin
        state_nxt = ld_en ? LD_IDLE : RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // high-half capture and fetch hold registers
  always_ff @(posedge clk_in or negedge RESET) begin
    if (!RESET) begin
      hi_lat     <= '0;
      hold_q     <= NOP_BYTE;
      fetch_addr <= '0;
      fetch_q    <= 1'b0;
      stale      <= 1'b0;
    end else begin
      if (p == P_HI) hi_lat <= PC_HL;
      fetch_q <= fetch_now;
      if (fetch_now) begin
        hold_q     <= rdata;
        fetch_addr <= raddr;
      end
      if (state != RUN)   stale <= 1'b1;
      else if (fetch_now) stale <= 1'b0;
    end
  end

  // instruction bus: live read in the fetch phase, held byte otherwise, NOP while loading
  always_comb begin
    rom_data = NOP_BYTE;
    if (state == RUN) begin
      if (p == P_FETCH) rom_data = rdata;
      else if (!stale)  rom_data = hold_q;
    end
  end

endmodule

// File: doc/dg0045_rom_server.md
DG0045_ROM_SERVER -- requirements
Module: dg0045_rom_server

Interface
REQ-001 SHALL have port clk_in, input, 1 bit: system clock, the same clock that drives the DG0045 core. All state advances on the rising edge.
REQ-002 SHALL have port RESET, input, 1 bit: asynchronous, active-low reset, shared with the core's rst_n.
REQ-003 SHALL have port PC_HL, input, 5 bits: the core's multiplexed program-counter pins.
REQ-004 SHALL have port PC_MUX, output, 1 bit: half-select driven to the core. 1 selects {PU,PL[5]}; 0 selects PL[4:0].
REQ-005 SHALL have port rom_data, output, 8 bits: instruction byte driven to the core's ui_in.
REQ-006 SHALL have port ld_en, input, 1 bit: load-mode request, level-sensitive.
REQ-007 SHALL have port ld_base, input, 10 bits: start address for loading, sampled on entry to load mode.
REQ-008 SHALL have port ld_valid, input, 1 bit: a load byte is offered.
REQ-009 SHALL have port ld_data, input, 8 bits: the load byte.
REQ-010 SHALL have port ld_ready, output, 1 bit: the server accepts the offered byte this cycle.
REQ-011 SHALL have port fetch_addr, output, 10 bits: last assembled fetch address {PU,PL}.
REQ-012 SHALL have port fetch_stb, output, 1 bit: one-cycle pulse marking each completed fetch.

Function
REQ-013 SHALL run a 3-bit phase counter p that increments by 1 each clk_in and wraps 7->0. p mirrors the core's clock divider, since both come out of the same reset.
REQ-014 SHALL drive PC_MUX=1 during p==2 and PC_MUX=0 in every other phase.
REQ-015 SHALL capture PC_HL into hi_lat[4:0] ({PU,PL5}) on the edge where p goes 2->3.
REQ-016 SHALL, in state RUN during p==3, drive rom_data combinationally as rom[{hi_lat,PC_HL}], where PC_HL is taken as PL[4:0].
REQ-017 SHALL, on the edge where p goes 3->4, register that byte into hold_q, load fetch_addr with {hi_lat,PC_HL}, and pulse fetch_stb high for exactly one cycle (during p==4).
REQ-018 SHALL drive rom_data=hold_q in state RUN in every phase except p==3.
REQ-019 SHALL implement the FSM states RUN, LD_IDLE and LD_WR.
REQ-020 SHALL make these FSM transitions:
- RUN -> LD_IDLE when ld_en==1; on that transition, ptr <= ld_base.
- LD_IDLE -> LD_WR when ld_valid && ld_ready.
- LD_WR -> LD_IDLE when ld_en==1.
- LD_WR -> RUN when ld_en==0.
- LD_IDLE -> RUN when ld_en==0 and ld_valid==0.
REQ-021 SHALL assert ld_ready=1 only in LD_IDLE with ld_en==1.
REQ-022 SHALL, on each accepted handshake, write ld_data to rom[ptr] at that edge and then increment ptr modulo 1024 (1023 -> 0).
REQ-023 SHALL drive rom_data=8'h00 (NOP) in every phase while in LD_IDLE or LD_WR. hold_q, fetch_addr and fetch_stb SHALL NOT update in those states.
REQ-024 SHALL, when the state returns to RUN, resume fetch behaviour at the next p==3. No fetch SHALL be reconstructed in a partially elapsed cycle.
REQ-025 SHALL, if ld_en drops while a write is pending, complete that write in LD_WR before returning to RUN.
REQ-026 SHALL make the p counter independent of FSM state; p SHALL keep counting in every state.

Reset
REQ-027 SHALL, while RESET==0, set the following values:
- p=0, state=RUN, hi_lat=0, hold_q=8'h00, ptr=0.
- fetch_addr=0, fetch_stb=0, ld_ready=0.
- PC_MUX=0, rom_data=8'h00.
REQ-028 SHALL leave ROM contents unaffected by reset.
REQ-029 SHALL, when RESET asserts mid-write, abort the write.

Structure
REQ-030 SHALL place the following in package dg0045_pkg:
- phase constants P_HI=2, P_FETCH=3, P_HOLD=4;
- NOP_BYTE=8'h00;
- the FSM state enum;
- ROM_AW=10.
REQ-031 SHALL instantiate exactly one sub-module, dg0045_rom_1kx8, with a synchronous write port (we, waddr, wdata) and a combinational read port (raddr, rdata).

Verification
REQ-032 SHALL cover reset: after RESET release, PC_MUX over phases 0..7 = 0,0,1,0,0,0,0,0, and rom_data=8'h00.
REQ-033 SHALL cover load: ld_en=1, ld_base=10'h000, then bytes 0x18, 0x3F, 0x80 -> rom[0..2] hold those bytes, and ld_ready pattern = 1,0,1,0,1.
REQ-034 SHALL cover fetch: model the core with PC=10'h3E5 (PC_HL=5'h1F during p==2, 5'h05 during p==3) and rom[0x3E5]=0xC7 -> rom_data=0xC7 during p==3, fetch_addr=0x3E5, and fetch_stb high during p==4.
REQ-035 SHALL cover pointer wrap: ld_base=10'h3FF and two bytes 0xAA, 0x55 -> rom[0x3FF]=0xAA and rom[0x000]=0x55.
REQ-036 SHALL cover load exit: ld_en dropped in the same cycle as a handshake -> the byte is written, the state returns to RUN, and rom_data=0x00 until the next p==3.
